// File: rtl/hash_inverse_shared_stream_pkg.sv
// Shared types and constants for the streaming inverse shared-array hash.
// Widths here are the defaults the top and mapper parameters pick up.
package hash_inverse_shared_stream_pkg;

  localparam int x_cord_width_gp        = 2;
  localparam int y_cord_width_gp        = 2;
  localparam int hash_width_gp          = 4;
  localparam int len_width_gp           = 8;
  localparam int epa_word_addr_width_gp = 4;

  // Largest stripe hash that maps to a real EVA layout.
  localparam int hash_max_gp = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef struct packed {
    logic [x_cord_width_gp-1:0]        x;
    logic [y_cord_width_gp-1:0]        y;
    logic [hash_width_gp-1:0]          hash;
    logic [epa_word_addr_width_gp-1:0] addr;
    logic [len_width_gp-1:0]           len;
  } req_t;

endpackage

// File: rtl/hash_inverse_shared_stream_map.sv
// Combinational (x, y, hash, addr) -> shared EVA mapper: eva = {a[aw-1:h], y, x, a[h-1:0]}.
// Hashes above the legal maximum map to zero.
module hash_inverse_shared
  import hash_inverse_shared_stream_pkg::*;
#(
  parameter int x_cord_width_p = x_cord_width_gp,
  parameter int y_cord_width_p = y_cord_width_gp,
  parameter int hash_width_p   = hash_width_gp,
  parameter int aw_p           = epa_word_addr_width_gp,
  parameter int width_p        = x_cord_width_p + y_cord_width_p + aw_p
) (
  input  logic [x_cord_width_p-1:0] x_i,
  input  logic [y_cord_width_p-1:0] y_i,
  input  logic [hash_width_p-1:0]   hash_i,
  input  logic [aw_p-1:0]           addr_i,
  output logic [width_p-1:0]        eva_o
);

  logic [width_p-1:0] a_ext;
  logic [width_p-1:0] yx_ext;
  logic [width_p-1:0] low_mask;
  int                 hs;

  always_comb begin
    eva_o    = '0;
    a_ext    = width_p'(addr_i);
    yx_ext   = width_p'({y_i, x_i});
    low_mask = '0;
    hs       = 0;
    if (hash_i <= hash_width_p'(hash_max_gp)) begin
      hs       = 32'(hash_i);
      low_mask = (width_p'(1) << hs) - width_p'(1);
      // High address bits move above the tile coordinates; low h bits stay in place.
      eva_o    = ((a_ext >> hs) << (hs + x_cord_width_p + y_cord_width_p))
               | (yx_ext << hs)
               | (a_ext & low_mask);
    end
  end

endmodule

// File: rtl/hash_inverse_shared_stream.sv
// Streams shared EVAs for a run of local words, one beat per cycle under v_o/yumi_i.
// HASH_INVERSE_SHARED_RANGE_CHECK_EN adds err_o for illegal hash and address wrap.
module hash_inverse_shared_stream
  import hash_inverse_shared_stream_pkg::*;
#(
  parameter int x_cord_width_p = x_cord_width_gp,
  parameter int y_cord_width_p = y_cord_width_gp,
  parameter int hash_width_p   = hash_width_gp,
  parameter int len_width_p    = len_width_gp,
  parameter int width_p        = x_cord_width_p + y_cord_width_p + epa_word_addr_width_gp
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              v_i,
  output logic                              ready_o,
  input  logic [x_cord_width_p-1:0]         x_i,
  input  logic [y_cord_width_p-1:0]         y_i,
  input  logic [hash_width_p-1:0]           hash_i,
  input  logic [epa_word_addr_width_gp-1:0] addr_i,
  input  logic [len_width_p-1:0]            len_i,
  output logic                              v_o,
  output logic [width_p-1:0]                eva_o,
  output logic                              last_o,
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
  output logic                              err_o,
`endif
  input  logic                              yumi_i
);

  state_e state_q, state_d;
  req_t   req_q,   req_d;
  logic   last_q,  last_d;
  logic   err_q,   err_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          req_d.x    = x_i;
          req_d.y    = y_i;
          req_d.hash = hash_i;
          req_d.addr = addr_i;
          req_d.len  = len_i;
          last_d     = (len_i == '0);
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
          if (hash_i > hash_width_p'(hash_max_gp)) begin
            err_d  = 1'b1;
            last_d = 1'b0;
          end else begin
            state_d = STREAM;
          end
`else
          state_d = STREAM;
`endif
        end
      end
      STREAM: begin
        if (yumi_i) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            req_d.addr = req_q.addr + 1'b1;
            req_d.len  = req_q.len - 1'b1;
            // len counts remaining beats after this one, so 1 means the next beat is final.
            last_d     = (req_q.len == len_width_p'(1));
            err_d      = &req_q.addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  hash_inverse_shared #(
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p),
    .hash_width_p  (hash_width_p),
    .aw_p          (epa_word_addr_width_gp),
    .width_p       (width_p)
  ) u_map (
    .x_i   (req_q.x),
    .y_i   (req_q.y),
    .hash_i(req_q.hash),
    .addr_i(req_q.addr),
    .eva_o (eva_o)
  );

  assign ready_o = (state_q == IDLE);
  assign v_o     = (state_q == STREAM);
  assign last_o  = last_q;

`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_hash_inverse_shared_stream.sv
// Randomized and directed checks of hash_inverse_shared_stream against an arithmetic model.
module tb_hash_inverse_shared_stream;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       v_i = 1'b0;
  logic       ready_o;
  logic [1:0] x_i = '0;
  logic [1:0] y_i = '0;
  logic [3:0] hash_i = '0;
  logic [3:0] addr_i = '0;
  logic [7:0] len_i = '0;
  logic       v_o;
  logic [7:0] eva_o;
  logic       last_o;
  logic       yumi_i = 1'b0;
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
  logic       err_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got_eva[$];
  bit         got_last[$];
  bit         got_err[$];
  logic [7:0] exp_eva[$];
  bit         exp_last[$];
  int         hold_changes;

  hash_inverse_shared_stream dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .x_i    (x_i),
    .y_i    (y_i),
    .hash_i (hash_i),
    .addr_i (addr_i),
    .len_i  (len_i),
    .v_o    (v_o),
    .eva_o  (eva_o),
    .last_o (last_o),
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
    .err_o  (err_o),
`endif
    .yumi_i (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference layout: high address bits above {y,x}, low h bits below.
  function automatic logic [7:0] ref_eva(int x, int y, int h, int a);
    if (h > 3) return 8'h00;
    return 8'((a >> h) * (1 << (h + 4)) + (y * 4 + x) * (1 << h) + (a % (1 << h)));
  endfunction

  task automatic build_exp(int x, int y, int h, int a, int len);
    exp_eva.delete();
    exp_last.delete();
    for (int i = 0; i <= len; i++) begin
      exp_eva.push_back(ref_eva(x, y, h, (a + i) % 16));
      exp_last.push_back(i == len);
    end
  endtask

  task automatic send(int x, int y, int h, int a, int len);
    int w = 0;
    while (ready_o !== 1'b1 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    if (ready_o !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_wait ready_o=%b required 1", ready_o);
    end
    x_i = 2'(x); y_i = 2'(y); hash_i = 4'(h); addr_i = 4'(a); len_i = 8'(len);
    v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  // Consumes beats starting at the current negedge; stall0 cycles of yumi=0 on the first beat.
  task automatic collect(int stall0, int yumi_pct);
    bit fresh = 1'b1;
    bit done = 1'b0;
    bit take;
    logic [7:0] pe = '0;
    logic pl = 1'b0;
    int stalled = 0;
    got_eva.delete(); got_last.delete(); got_err.delete();
    hold_changes = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (v_o === 1'b1) begin
        if (!fresh) begin
          if (eva_o !== pe || last_o !== pl) hold_changes++;
        end else begin
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
          got_err.push_back(err_o);
`else
          got_err.push_back(1'b0);
`endif
        end
        pe = eva_o; pl = last_o;
        if (got_eva.size() == 0 && stalled < stall0) begin
          take = 1'b0;
          stalled++;
        end else begin
          take = ($urandom_range(99) < yumi_pct);
        end
        if (take) begin
          got_eva.push_back(eva_o);
          got_last.push_back(last_o);
          yumi_i = 1'b1;
          fresh = 1'b1;
          if (last_o === 1'b1) done = 1'b1;
        end else begin
          yumi_i = 1'b0;
          fresh = 1'b0;
        end
      end else begin
        yumi_i = 1'b0;
      end
      @(negedge clk_i);
    end
    yumi_i = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL collect_timeout beats=%0d required final beat", got_eva.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    vectors++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || last_o !== 1'b0 || eva_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_values ready=%b v=%b last=%b eva=%h required 1 0 0 00", ready_o, v_o, last_o, eva_o);
    end
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err err=%b required 0", err_o);
    end
`endif
    reset_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset ready=%b v=%b required 1 0", ready_o, v_o);
    end
  endtask

  task automatic test_single();
    send(1, 2, 0, 3, 0);
    vectors++;
    if (v_o !== 1'b1 || eva_o !== 8'h39 || last_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat v=%b eva=%h last=%b required 1 39 1", v_o, eva_o, last_o);
    end
    collect(0, 100);
    vectors++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready ready=%b v=%b required 1 0", ready_o, v_o);
    end
  endtask

  task automatic test_run(string name, int x, int y, int h, int a, int len, int stall0, int pct);
    send(x, y, h, a, len);
    build_exp(x, y, h, a, len);
    collect(stall0, pct);
    vectors++;
    if (got_eva.size() != exp_eva.size()) begin
      miscompares++;
      $display("FAIL %s_count got %0d beats required %0d", name, got_eva.size(), exp_eva.size());
    end
    for (int i = 0; i < got_eva.size() && i < exp_eva.size(); i++) begin
      vectors++;
      if (got_eva[i] !== exp_eva[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL %s_beat%0d eva=%h last=%b required %h %b", name, i, got_eva[i], got_last[i], exp_eva[i], exp_last[i]);
      end
    end
    vectors++;
    if (hold_changes != 0) begin
      miscompares++;
      $display("FAIL %s_hold changes=%0d required 0", name, hold_changes);
    end
  endtask

  task automatic test_burst();
    test_run("burst", 3, 1, 2, 6, 2, 0, 100);
    vectors++;
    if (got_eva.size() == 3 && (got_eva[0] !== 8'h5E || got_eva[1] !== 8'h5F || got_eva[2] !== 8'h9C)) begin
      miscompares++;
      $display("FAIL burst_literal %h %h %h required 5e 5f 9c", got_eva[0], got_eva[1], got_eva[2]);
    end
  endtask

  task automatic test_wrap();
    test_run("wrap", 0, 0, 0, 15, 1, 0, 100);
    vectors++;
    if (got_eva.size() == 2 && (got_eva[0] !== 8'hF0 || got_eva[1] !== 8'h00)) begin
      miscompares++;
      $display("FAIL wrap_literal %h %h required f0 00", got_eva[0], got_eva[1]);
    end
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
    vectors++;
    if (got_err.size() != 2 || got_err[0] !== 1'b0 || got_err[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_err pattern size=%0d required err only on second beat", got_err.size());
    end
`endif
  endtask

  task automatic test_stall();
    test_run("stall", 3, 1, 2, 6, 2, 3, 100);
  endtask

  task automatic test_bad_hash();
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
    send(1, 1, 5, 2, 1);
    vectors++;
    if (err_o !== 1'b1 || v_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_hash_err err=%b v=%b ready=%b required 1 0 1", err_o, v_o, ready_o);
    end
    @(negedge clk_i);
    vectors++;
    if (err_o !== 1'b0 || v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_hash_pulse err=%b v=%b required 0 0", err_o, v_o);
    end
`else
    test_run("bad_hash", 1, 1, 5, 2, 1, 0, 100);
`endif
  endtask

  task automatic test_reset_mid();
    send(3, 1, 2, 6, 2);
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    vectors++;
    if (v_o !== 1'b1 || eva_o !== 8'h5F) begin
      miscompares++;
      $display("FAIL reset_mid_second v=%b eva=%h required 1 5f", v_o, eva_o);
    end
    reset_i = 1'b1;
    #1;
    vectors++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort v=%b ready=%b last=%b required 0 1 0", v_o, ready_o, last_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    test_run("after_reset", 1, 2, 0, 3, 0, 0, 100);
  endtask

  task automatic test_back_to_back();
    x_i = 2'd2; y_i = 2'd3; hash_i = 4'd1; addr_i = 4'd9; len_i = 8'd1;
    v_i = 1'b1;
    @(negedge clk_i);
    // Second request held on the bus while the first run streams.
    x_i = 2'd1; y_i = 2'd0; hash_i = 4'd3; addr_i = 4'd14; len_i = 8'd2;
    build_exp(2, 3, 1, 9, 1);
    collect(0, 100);
    for (int i = 0; i < got_eva.size() && i < exp_eva.size(); i++) begin
      vectors++;
      if (got_eva[i] !== exp_eva[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL b2b_a_beat%0d eva=%h last=%b required %h %b", i, got_eva[i], got_last[i], exp_eva[i], exp_last[i]);
      end
    end
    vectors++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_dead_cycle v=%b ready=%b required 0 1", v_o, ready_o);
    end
    @(negedge clk_i);
    v_i = 1'b0;
    build_exp(1, 0, 3, 14, 2);
    collect(0, 100);
    vectors++;
    if (got_eva.size() != exp_eva.size()) begin
      miscompares++;
      $display("FAIL b2b_b_count got %0d required %0d", got_eva.size(), exp_eva.size());
    end
    for (int i = 0; i < got_eva.size() && i < exp_eva.size(); i++) begin
      vectors++;
      if (got_eva[i] !== exp_eva[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("FAIL b2b_b_beat%0d eva=%h last=%b required %h %b", i, got_eva[i], got_last[i], exp_eva[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    int x, y, h, a, len;
    for (int n = 0; n < 30; n++) begin
      x = $urandom_range(3);
      y = $urandom_range(3);
`ifdef HASH_INVERSE_SHARED_RANGE_CHECK_EN
      h = $urandom_range(3);
`else
      h = $urandom_range(5);
`endif
      a = $urandom_range(15);
      len = $urandom_range(7);
      test_run("random", x, y, h, a, len, $urandom_range(2), 60);
      repeat ($urandom_range(2)) @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_stall();
    test_bad_hash();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
